inter_pred_cwin_fetch: RTL and testbench

INTER_PRED_CWIN_FETCH -- requirements
Module: inter_pred_cwin_fetch

---
 rtl/inter_pred_cwin_fetch_pkg.sv | 21 ++
 rtl/inter_pred_cwin_fetch_coord_clamp.sv | 26 ++
 rtl/inter_pred_cwin_fetch.sv | 169 ++++++++++++++++
 tb/tb_inter_pred_cwin_fetch.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/inter_pred_cwin_fetch_pkg.sv
// Shared constants for the chroma window fetcher: FSM encoding, grid size and
// the quadrant origin table used to slice 3x3 windows out of the 5x5 grid.
package inter_pred_cwin_fetch_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_EMIT  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam int GRID = 5;
  localparam int WIN  = 3;

  // Per quadrant: {row origin[5:3], col origin[2:0]}; entry 0 is the top-left window.
  localparam logic [3:0][5:0] QUAD_ORIGIN = {6'o22, 6'o20, 6'o02, 6'o00};

  function automatic logic [4:0] grid_idx(input logic [2:0] row, input logic [2:0] col);
    return 5'(row) * 5'(GRID) + 5'(col);
  endfunction

endpackage

// File: rtl/inter_pred_cwin_fetch_coord_clamp.sv
// Clamps a signed block coordinate plus a small grid offset into [0, MAX_C].
module cwin_coord_clamp #(
  parameter int MAX_C = 87,
  parameter int OUT_W = 7
) (
  input  logic [10:0]      i_base,
  input  logic [2:0]       i_off,
  output logic [OUT_W-1:0] o_coord
);

  logic [11:0] w_sum;

  // Sign-extend the base so bit 11 of the sum flags a negative coordinate.
  assign w_sum = {i_base[10], i_base} + {9'd0, i_off};

  always_comb begin
    if (w_sum[11]) begin
      o_coord = '0;
    end else if (w_sum > 12'(MAX_C)) begin
      o_coord = OUT_W'(MAX_C);
    end else begin
      o_coord = w_sum[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/inter_pred_cwin_fetch.sv
// Fetches a clamped 5x5 chroma grid from reference memory and presents it as four
// 3x3 quadrant windows. Optional feature macro: CWIN_FULLPEL_SKIP_EN.
module inter_pred_cwin_fetch
  import inter_pred_cwin_fetch_pkg::*;
#(
  parameter int PIC_W_C = 88,
  parameter int PIC_H_C = 72,
  parameter int ADDR_W  = 13
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic signed [10:0] blk_x_int,
  input  logic signed [10:0] blk_y_int,
  input  logic [2:0]         xFracC_in,
  input  logic [2:0]         yFracC_in,
  output logic               ref_rd_en,
  output logic [ADDR_W-1:0]  ref_rd_addr,
  input  logic [7:0]         ref_rd_data,
  output logic               win_valid,
  input  logic               win_ready,
  output logic [7:0]         win_0_0,
  output logic [7:0]         win_0_1,
  output logic [7:0]         win_0_2,
  output logic [7:0]         win_1_0,
  output logic [7:0]         win_1_1,
  output logic [7:0]         win_1_2,
  output logic [7:0]         win_2_0,
  output logic [7:0]         win_2_1,
  output logic [7:0]         win_2_2,
  output logic [2:0]         xFracC,
  output logic [2:0]         yFracC,
  output logic [1:0]         win_idx,
  output logic               busy,
  output logic               done
);

  localparam int CX_W = $clog2(PIC_W_C);
  localparam int CY_W = $clog2(PIC_H_C);

  logic [2:0]         r_state;
  logic signed [10:0] r_bx, r_by;
  logic [2:0]         r_row, r_col, r_last;
  logic               r_wr_vld;
  logic [4:0]         r_wr_idx;
  logic [1:0]         r_idx;
  logic [2:0]         r_xfrac, r_yfrac;
  logic [7:0]         r_buf [GRID*GRID];

  logic [CX_W-1:0]    w_cx;
  logic [CY_W-1:0]    w_cy;
  logic               w_fullpel;
  logic               w_start_ok;
  logic [2:0]         w_last;
  logic [5:0]         w_org;
  logic [7:0]         w_win [WIN][WIN];

`ifdef CWIN_FULLPEL_SKIP_EN
  assign w_fullpel = (xFracC_in == 3'd0) && (yFracC_in == 3'd0);
`else
  assign w_fullpel = 1'b0;
`endif

  assign w_start_ok = (r_state == ST_IDLE) && start;
  assign w_last     = w_fullpel ? 3'(GRID - 2) : 3'(GRID - 1);

  cwin_coord_clamp #(.MAX_C(PIC_W_C - 1), .OUT_W(CX_W)) u_clamp_x (
    .i_base (r_bx),
    .i_off  (r_col),
    .o_coord(w_cx)
  );

  cwin_coord_clamp #(.MAX_C(PIC_H_C - 1), .OUT_W(CY_W)) u_clamp_y (
    .i_base (r_by),
    .i_off  (r_row),
    .o_coord(w_cy)
  );

  assign ref_rd_en   = (r_state == ST_FETCH);
  assign ref_rd_addr = ref_rd_en ? (ADDR_W'(w_cy) * ADDR_W'(PIC_W_C) + ADDR_W'(w_cx)) : '0;
  assign win_valid   = (r_state == ST_EMIT);
  assign busy        = (r_state == ST_FETCH) || (r_state == ST_DRAIN) || (r_state == ST_EMIT);
  assign done        = (r_state == ST_DONE);
  assign win_idx     = r_idx;
  assign xFracC      = r_xfrac;
  assign yFracC      = r_yfrac;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_bx     <= '0;
      r_by     <= '0;
      r_row    <= '0;
      r_col    <= '0;
      r_last   <= '0;
      r_wr_vld <= 1'b0;
      r_wr_idx <= '0;
      r_idx    <= '0;
      r_xfrac  <= '0;
      r_yfrac  <= '0;
    end else begin
      // Read data returns one cycle late, so remember which grid slot it belongs to.
      r_wr_vld <= ref_rd_en;
      r_wr_idx <= grid_idx(r_row, r_col);
      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_state <= ST_FETCH;
            r_bx    <= blk_x_int;
            r_by    <= blk_y_int;
            r_row   <= '0;
            r_col   <= '0;
            r_last  <= w_last;
            r_idx   <= '0;
            r_xfrac <= xFracC_in;
            r_yfrac <= yFracC_in;
          end
        end
        ST_FETCH: begin
          if (r_col == r_last) begin
            r_col <= '0;
            if (r_row == r_last) r_state <= ST_DRAIN;
            else                 r_row   <= r_row + 3'd1;
          end else begin
            r_col <= r_col + 3'd1;
          end
        end
        ST_DRAIN: r_state <= ST_EMIT;
        ST_EMIT: begin
          if (win_ready) begin
            r_idx <= r_idx + 2'd1;
            if (r_idx == 2'd3) r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: the pixel buffer has no reset; every entry presented is written before
  // win_valid rises, and the window outputs are forced to 0 while win_valid is low.
  always_ff @(posedge clk) begin
    if (w_start_ok && w_fullpel) begin
      for (int i = 0; i < GRID*GRID; i++) r_buf[i] <= 8'd0;
    end
    if (r_wr_vld) r_buf[r_wr_idx] <= ref_rd_data;
  end

  always_comb begin
    w_org = QUAD_ORIGIN[r_idx];
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN; c++) begin
        w_win[r][c] = win_valid ? r_buf[grid_idx(w_org[5:3] + 3'(r), w_org[2:0] + 3'(c))] : 8'd0;
      end
    end
  end

  assign win_0_0 = w_win[0][0];
  assign win_0_1 = w_win[0][1];
  assign win_0_2 = w_win[0][2];
  assign win_1_0 = w_win[1][0];
  assign win_1_1 = w_win[1][1];
  assign win_1_2 = w_win[1][2];
  assign win_2_0 = w_win[2][0];
  assign win_2_1 = w_win[2][1];
  assign win_2_2 = w_win[2][2];

endmodule

// File: tb/tb_inter_pred_cwin_fetch.sv
// Scoreboard bench for inter_pred_cwin_fetch: stimulus pushes expected reads and
// windows into queues, a negedge monitor pops and compares them.
module tb_inter_pred_cwin_fetch;

  localparam int PW = 88;
  localparam int PH = 72;
  localparam int AW = 13;
`ifdef CWIN_FULLPEL_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]  idx;
    logic [2:0]  xf;
    logic [2:0]  yf;
    logic [71:0] win;
  } win_t;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic signed [10:0] blk_x_int = '0;
  logic signed [10:0] blk_y_int = '0;
  logic [2:0]         xFracC_in = '0;
  logic [2:0]         yFracC_in = '0;
  logic               ref_rd_en;
  logic [AW-1:0]      ref_rd_addr;
  logic [7:0]         ref_rd_data = '0;
  logic               win_valid;
  logic               win_ready = 1'b1;
  logic [7:0]         win_0_0, win_0_1, win_0_2, win_1_0, win_1_1, win_1_2, win_2_0, win_2_1, win_2_2;
  logic [2:0]         xFracC, yFracC;
  logic [1:0]         win_idx;
  logic               busy, done;

  int n_pass = 0, n_tot = 0, cyc = 0, n_reads = 0, n_done = 0;
  int exp_valid_cyc = -1, exp_done_cyc = -1, cur_lim = 5;
  bit seen_valid = 1'b1;
  win_t          exp_q[$];
  logic [AW-1:0] addr_q[$];
  logic [7:0]    mem [PW*PH];
  int            pat = 0;
  logic [7:0]    g [5][5];

  inter_pred_cwin_fetch #(.PIC_W_C(PW), .PIC_H_C(PH), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .blk_x_int(blk_x_int), .blk_y_int(blk_y_int),
    .xFracC_in(xFracC_in), .yFracC_in(yFracC_in),
    .ref_rd_en(ref_rd_en), .ref_rd_addr(ref_rd_addr), .ref_rd_data(ref_rd_data),
    .win_valid(win_valid), .win_ready(win_ready),
    .win_0_0(win_0_0), .win_0_1(win_0_1), .win_0_2(win_0_2),
    .win_1_0(win_1_0), .win_1_1(win_1_1), .win_1_2(win_1_2),
    .win_2_0(win_2_0), .win_2_1(win_2_1), .win_2_2(win_2_2),
    .xFracC(xFracC), .yFracC(yFracC), .win_idx(win_idx),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (ref_rd_en) ref_rd_data <= (int'(ref_rd_addr) < PW*PH) ? mem[ref_rd_addr] : 8'hEE;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  function automatic logic [7:0] pix(input int x, input int y);
    return (pat == 0) ? 8'((x + y) & 255) : 8'((3*x + 7*y + 1) & 255);
  endfunction

  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  task automatic load_mem();
    for (int a = 0; a < PW*PH; a++) mem[a] = pix(a % PW, a / PW);
  endtask

  function automatic win_t exp_win(input int q, input logic [2:0] xf, input logic [2:0] yf);
    win_t e;
    e.idx = 2'(q);
    e.xf  = xf;
    e.yf  = yf;
    e.win = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        e.win[(r*3+c)*8 +: 8] = g[(q/2)*2 + r][(q%2)*2 + c];
    return e;
  endfunction

  function automatic win_t act_win();
    win_t a;
    a.idx = win_idx;
    a.xf  = xFracC;
    a.yf  = yFracC;
    a.win = {win_2_2, win_2_1, win_2_0, win_1_2, win_1_1, win_1_0, win_0_2, win_0_1, win_0_0};
    return a;
  endfunction

  function automatic logic [127:0] all_outs();
    return 128'({busy, done, win_valid, ref_rd_en, ref_rd_addr, act_win()});
  endfunction

  // Monitor: every read, every accepted window, valid rise and done pulse.
  always @(negedge clk) begin
    if (ref_rd_en) begin
      n_reads++;
      if (addr_q.size() == 0) check("rd_unexpected", 128'(ref_rd_addr), 128'(0) - 128'(1));
      else check("rd_addr", 128'(ref_rd_addr), 128'(addr_q.pop_front()));
    end
    if (win_valid && !seen_valid) begin
      seen_valid = 1'b1;
      check("valid_rise_cycle", 128'(cyc), 128'(exp_valid_cyc));
    end
    if (win_valid && win_ready) begin
      if (exp_q.size() == 0) check("win_unexpected", 128'(act_win()), 128'(0) - 128'(1));
      else check("win_accept", 128'(act_win()), 128'(exp_q.pop_front()));
    end
    if (done) begin
      n_done++;
      check("done_cycle", 128'(cyc), 128'(exp_done_cyc));
    end
  end

  task automatic setup_op(input int bx, input int by, input logic [2:0] xf, input logic [2:0] yf,
                          input int stall);
    bit full;
    full    = SKIP && (xf == 3'd0) && (yf == 3'd0);
    cur_lim = full ? 4 : 5;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        g[r][c] = (full && (r == 4 || c == 4)) ? 8'd0
                  : pix(clampi(bx + c, PW - 1), clampi(by + r, PH - 1));
    for (int r = 0; r < cur_lim; r++)
      for (int c = 0; c < cur_lim; c++)
        addr_q.push_back(AW'(clampi(by + r, PH - 1) * PW + clampi(bx + c, PW - 1)));
    for (int q = 0; q < 4; q++) exp_q.push_back(exp_win(q, xf, yf));
    exp_valid_cyc = cyc + (full ? 18 : 27);
    exp_done_cyc  = exp_valid_cyc + 4 + stall;
    seen_valid    = 1'b0;
    start     = 1'b1;
    blk_x_int = 11'(bx);
    blk_y_int = 11'(by);
    xFracC_in = xf;
    yFracC_in = yf;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_op(input int bx, input int by, input logic [2:0] xf, input logic [2:0] yf,
                        input int stall, input bit poke);
    int   r0, d0, w;
    win_t e1;
    @(posedge clk); #1;
    r0 = n_reads;
    d0 = n_done;
    setup_op(bx, by, xf, yf, stall);
    check("busy_after_start", 128'(busy), 128'(1));
    if (poke) begin
      repeat (3) @(posedge clk);
      #1;
      start = 1'b1; blk_x_int = '0; blk_y_int = '0; xFracC_in = 3'd7; yFracC_in = 3'd7;
      @(posedge clk); #1;
      start = 1'b0;
    end
    if (stall > 0) begin
      while (cyc < exp_valid_cyc) begin @(posedge clk); #1; end
      @(posedge clk); #1;
      win_ready = 1'b0;
      e1 = exp_win(1, xf, yf);
      for (int k = 0; k < stall; k++) begin
        @(negedge clk);
        check("stall_hold", 128'({win_valid, act_win()}), 128'({1'b1, e1}));
        @(posedge clk); #1;
      end
      win_ready = 1'b1;
    end
    w = 0;
    while (n_done == d0 && w < 100) begin @(negedge clk); w++; end
    check("done_seen", 128'(n_done - d0), 128'(1));
    repeat (3) @(negedge clk);
    check("done_single", 128'(n_done - d0), 128'(1));
    check("read_count", 128'(n_reads - r0), 128'(cur_lim * cur_lim));
    check("queues_drained", 128'(exp_q.size() + addr_q.size()), 128'(0));
    check("idle_after_done", 128'({busy, win_valid, ref_rd_en}), 128'(0));
  endtask

  task automatic reset_mid_fetch();
    int d0;
    @(posedge clk); #1;
    d0 = n_done;
    setup_op(30, 40, 3'd4, 3'd4, 0);
    repeat (11) @(posedge clk);
    #1;
    check("fetch_before_reset", 128'({busy, ref_rd_en}), 128'(2'b11));
    reset = 1'b1;
    #1;
    exp_q.delete();
    addr_q.delete();
    exp_valid_cyc = -1;
    exp_done_cyc  = -1;
    seen_valid    = 1'b1;
    check("reset_async_clear", all_outs(), 128'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("idle_after_reset", all_outs(), 128'(0));
    repeat (40) @(negedge clk);
    check("no_done_after_reset", 128'(n_done - d0), 128'(0));
  endtask

  initial begin
    pat = 0;
    load_mem();
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", all_outs(), 128'(0));
    reset = 1'b0;
    @(negedge clk);
    check("idle_state", all_outs(), 128'(0));

    run_op(10, 20, 3'd3, 3'd5, 0, 1'b1);   // interior, (x+y) memory, start poked while busy
    pat = 1;
    load_mem();
    run_op(-2, -3, 3'd1, 3'd2, 0, 1'b0);   // top-left corner clamp
    run_op(86, 70, 3'd7, 3'd0, 0, 1'b0);   // right/bottom edge clamp
    run_op(40, 30, 3'd2, 3'd6, 5, 1'b0);   // backpressure on window 1
    reset_mid_fetch();
    run_op(5, 6, 3'd0, 3'd3, 0, 1'b0);     // normal op after reset
    run_op(12, 9, 3'd0, 3'd0, 0, 1'b0);    // full-pel fractions

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
